// File: rtl/sync_gray_ptr.sv
// Multi-stage synchroniser for a Gray-coded FIFO pointer entering the destination domain.
// Produces the binary pointer, its per-cycle advance, a priming flag and a sticky direction error.
module sync_gray_ptr #(
  parameter int unsigned PTR_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 dst_clk_i,
  input  logic                 dst_rst_i,
  input  logic [0:PTR_WIDTH-1] ptr_gray_i,
  input  logic                 err_clr_i,
  output logic [0:PTR_WIDTH-1] ptr_gray_o,
  output logic [0:PTR_WIDTH-1] ptr_bin_o,
  output logic [0:PTR_WIDTH-1] delta_o,
  output logic                 adv_o,
  output logic                 valid_o,
  output logic                 err_o
);

  localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);
  localparam logic [CntW-1:0] CntMax = CntW'(SYNC_STAGES + 1);

  logic [0:PTR_WIDTH-1] r_sync [SYNC_STAGES];
  logic [0:PTR_WIDTH-1] r_bin;
  logic [0:PTR_WIDTH-1] r_delta;
  logic                 r_adv;
  logic                 r_err;
  logic [CntW-1:0]      r_cnt;

  logic [0:PTR_WIDTH-1] w_bin_next;
  logic [0:PTR_WIDTH-1] w_delta;
  logic                 w_valid;
  logic                 w_set;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge dst_clk_i or negedge dst_rst_i) begin
    if (!dst_rst_i) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= ptr_gray_i;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Bit 0 is the MSB, so the running XOR walks from index 0 upwards.
  always_comb begin
    logic acc;
    acc        = 1'b0;
    w_bin_next = '0;
    for (int i = 0; i < int'(PTR_WIDTH); i++) begin
      acc           = acc ^ r_sync[SYNC_STAGES-1][i];
      w_bin_next[i] = acc;
    end
  end

  assign w_delta = w_bin_next - r_bin;
  assign w_valid = (r_cnt == CntMax);
  // A delta of half the range or more means the pointer moved backwards or overran.
  assign w_set   = w_valid && w_delta[0];

  always_ff @(posedge dst_clk_i or negedge dst_rst_i) begin
    if (!dst_rst_i) begin
      r_bin   <= '0;
      r_delta <= '0;
      r_adv   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_bin <= w_bin_next;
      if (w_valid) begin
        r_delta <= w_delta;
        r_adv   <= |w_delta;
      end else begin
        r_delta <= '0;
        r_adv   <= 1'b0;
        r_cnt   <= r_cnt + 1'b1;
      end
      r_err <= w_set | (r_err & ~err_clr_i);
    end
  end

  assign ptr_gray_o = r_sync[SYNC_STAGES-1];
  assign ptr_bin_o  = r_bin;
  assign delta_o    = r_delta;
  assign adv_o      = r_adv;
  assign valid_o    = w_valid;
  assign err_o      = r_err;

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Scoreboard bench for sync_gray_ptr: stimulus pushes hand-computed expectations per edge,
// a monitor pops and compares them on the falling edge.
module tb_sync_gray_ptr;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr   = 1'b0;
  logic [0:W-1] gin   = '0;
  logic [0:W-1] gray_o;
  logic [0:W-1] bin_o;
  logic [0:W-1] delta_o;
  logic         adv_o;
  logic         valid_o;
  logic         err_o;

  sync_gray_ptr #(
    .PTR_WIDTH  (W),
    .SYNC_STAGES(S)
  ) u_dut (
    .dst_clk_i (clk),
    .dst_rst_i (rst_n),
    .ptr_gray_i(gin),
    .err_clr_i (clr),
    .ptr_gray_o(gray_o),
    .ptr_bin_o (bin_o),
    .delta_o   (delta_o),
    .adv_o     (adv_o),
    .valid_o   (valid_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] d;
    logic       adv;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Gray codes of 0..15
  logic [7:0] gtab [16] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
                            8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08};

  task automatic push(input string nm, input logic [7:0] g, input logic [7:0] b,
                      input logic [7:0] d, input logic adv, input logic v, input logic e);
    exp_t x;
    x.g = g; x.b = b; x.d = d; x.adv = adv; x.valid = v; x.err = e;
    q_exp.push_back(x);
    q_name.push_back(nm);
  endtask

  // Apply inputs, take one edge, record what the outputs must be after it.
  task automatic cyc(input string nm, input logic [7:0] gi, input logic c,
                     input logic [7:0] eg, input logic [7:0] eb, input logic [7:0] ed,
                     input logic eadv, input logic ev, input logic ee);
    gin = gi;
    clr = c;
    @(posedge clk);
    #1;
    push(nm, eg, eb, ed, eadv, ev, ee);
  endtask

  // Reset (checked immediately), release with gi held, check priming and one settled cycle.
  task automatic prime(input string nm, input logic [7:0] gi, input logic [7:0] bi);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    gin   = gi;
    clr   = 1'b0;
    #1;
    push({nm, "_rst"}, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc({nm, "_e1"}, gi, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc({nm, "_e2"}, gi, 1'b0, gi,    8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc({nm, "_e3"}, gi, 1'b0, gi,    bi,    8'h00, 1'b0, 1'b1, 1'b0);
    cyc({nm, "_e4"}, gi, 1'b0, gi,    bi,    8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Count up from a primed zero pointer; n up to 18 drains the pipeline after Gray 15.
  task automatic count(input string nm, input int n);
    for (int k = 1; k <= n; k++) begin
      int ki;
      int kg;
      int kb;
      ki = (k > 15) ? 15 : k;
      kg = (k - 1 > 15) ? 15 : k - 1;
      kb = (k < 2) ? 0 : ((k - 2 > 15) ? 15 : k - 2);
      cyc($sformatf("%s%0d", nm, k), gtab[ki], 1'b0, gtab[kg], 8'(kb),
          (k >= 3 && k <= 17) ? 8'h01 : 8'h00, (k >= 3 && k <= 17), 1'b1, 1'b0);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        n_cmp++;
        if (gray_o !== e.g || bin_o !== e.b || delta_o !== e.d || adv_o !== e.adv ||
            valid_o !== e.valid || err_o !== e.err) begin
          n_err++;
          $display("FAIL %s: got gray=%h bin=%h delta=%h adv=%b valid=%b err=%b, want gray=%h bin=%h delta=%h adv=%b valid=%b err=%b",
                   nm, gray_o, bin_o, delta_o, adv_o, valid_o, err_o,
                   e.g, e.b, e.d, e.adv, e.valid, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, want finish before 200000");
    $fatal(1);
  end

  initial begin : stim
    // Priming with Gray 0x07 (bin 5) held through reset release
    prime("prime", 8'h07, 8'h05);

    // Step count Gray 0..15
    prime("cnt_prime", 8'h00, 8'h00);
    count("cnt", 18);

    // Jump bin 3 -> 7
    prime("jmp_prime", 8'h02, 8'h03);
    cyc("jmp_a", 8'h04, 1'b0, 8'h02, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("jmp_b", 8'h04, 1'b0, 8'h04, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("jmp_c", 8'h04, 1'b0, 8'h04, 8'h07, 8'h04, 1'b1, 1'b1, 1'b0);
    cyc("jmp_d", 8'h04, 1'b0, 8'h04, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0);

    // Wrap bin 0xFF -> 0x00
    prime("wrap_prime", 8'h80, 8'hFF);
    cyc("wrap_a", 8'h00, 1'b0, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("wrap_b", 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("wrap_c", 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
    cyc("wrap_d", 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Backward bin 0x10 -> 0x0F, sticky, clear, then set-vs-clear on the same edge
    prime("bk_prime", 8'h18, 8'h10);
    cyc("bk_a",      8'h08, 1'b0, 8'h18, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("bk_b",      8'h08, 1'b0, 8'h08, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("bk_set",    8'h08, 1'b0, 8'h08, 8'h0F, 8'hFF, 1'b1, 1'b1, 1'b1);
    cyc("bk_sticky", 8'h08, 1'b0, 8'h08, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc("bk_clr",    8'h08, 1'b1, 8'h08, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("bk_clr2",   8'h08, 1'b0, 8'h08, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("fw_a",      8'h18, 1'b0, 8'h08, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("fw_b",      8'h18, 1'b0, 8'h18, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("fw_c",      8'h18, 1'b0, 8'h18, 8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
    cyc("bk2_a",     8'h08, 1'b0, 8'h18, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("bk2_b",     8'h08, 1'b0, 8'h08, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("bk2_setclr", 8'h08, 1'b1, 8'h08, 8'h0F, 8'hFF, 1'b1, 1'b1, 1'b1);
    cyc("bk2_hold",  8'h08, 1'b0, 8'h08, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of counting, then re-prime on the held pointer (Gray 0x07, bin 5)
    prime("mid_prime", 8'h00, 8'h00);
    count("mid", 5);
    prime("mid_reprime", gtab[5], 8'h05);

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (q_exp.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
